// File: rtl/cakegame_button_conditioner_pkg.sv
// Shared definitions for the cakegame button conditioner: default sizes and FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cakegame_button_conditioner_pkg;

    localparam int N_BUTTONS_DEF       = 7;
    // 20 stable samples of the 1 kHz game clock = 20 ms of settled contact.
    localparam int DEBOUNCE_CYCLES_DEF = 20;
    localparam int CNT_W_DEF           = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HELD    = 2'd1,
        ST_CHORD   = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

endpackage

// File: rtl/cakegame_button_conditioner_debounce_bit.sv
// One button input: 2-flop synchronizer followed by a consecutive-sample debouncer.
// Latency: a clean edge on raw_i reaches stable_o 2 + DEBOUNCE_CYCLES cycles later.
// Backpressure: none; free-running, always samples.
// Ports: clock, reset (async active-low), raw_i (asynchronous pin), stable_o (debounced level).
module cakegame_button_conditioner_debounce_bit
    import cakegame_button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // cnt counts consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts it, so short glitches never flip stable.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/cakegame_button_conditioner.sv
// Turns raw bouncing cake buttons into a clean 0-or-one-hot level plus press/chord pulses.
// Latency: raw edge to buttons/press is 2 (sync) + DEBOUNCE_CYCLES + 1 (registered FSM output).
// Backpressure: none; enable=0 forces idle outputs while the debouncers keep tracking the pins.
// Ports: clock, reset (async active-low), enable, raw_buttons[N-1:0] in;
//        buttons[N-1:0] (level), press (1-cycle), chord (1-cycle) out.
module cakegame_button_conditioner
    import cakegame_button_conditioner_pkg::*;
#(
    parameter int N_BUTTONS       = N_BUTTONS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_BUTTONS-1:0] raw_buttons,
    output logic [N_BUTTONS-1:0] buttons,
    output logic                 press,
    output logic                 chord
);

    localparam logic [N_BUTTONS-1:0] ONE = {{(N_BUTTONS-1){1'b0}}, 1'b1};

    logic [N_BUTTONS-1:0] stable;
    logic                 any_set;
    logic                 multi_set;

    state_e               state_q, state_d;
    logic [N_BUTTONS-1:0] code_q, code_d;
    logic [N_BUTTONS-1:0] buttons_q, buttons_d;
    logic                 press_q, press_d;
    logic                 chord_q, chord_d;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_db
        cakegame_button_conditioner_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clock    (clock),
            .reset    (reset),
            .raw_i    (raw_buttons[i]),
            .stable_o (stable[i])
        );
    end

    // v & (v-1) clears the lowest set bit; anything left means popcount > 1.
    assign any_set   = |stable;
    assign multi_set = |(stable & (stable - ONE));

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        buttons_d = '0;
        press_d   = 1'b0;
        chord_d   = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (any_set && !multi_set) begin
                        state_d   = ST_HELD;
                        code_d    = stable;
                        buttons_d = stable;
                        press_d   = 1'b1;
                    end else if (multi_set) begin
                        state_d = ST_CHORD;
                        chord_d = 1'b1;
                    end
                end
                ST_HELD: begin
                    // Extra buttons joining the held one are ignored; only
                    // losing the latched button ends the press.
                    if ((stable & code_q) == '0) begin
                        state_d = ST_RELEASE;
                    end else begin
                        buttons_d = code_q;
                    end
                end
                ST_CHORD, ST_RELEASE: begin
                    if (!any_set) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            buttons_q <= '0;
            press_q   <= 1'b0;
            chord_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            buttons_q <= buttons_d;
            press_q   <= press_d;
            chord_q   <= chord_d;
        end
    end

    assign buttons = buttons_q;
    assign press   = press_q;
    assign chord   = chord_q;

endmodule

// File: tb/tb_cakegame_button_conditioner.sv
module tb_cakegame_button_conditioner;

    localparam int N   = 7;
    localparam int DEB = 20;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic [N-1:0] raw;
    logic [N-1:0] buttons;
    logic         press;
    logic         chord;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cakegame_button_conditioner dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .raw_buttons (raw),
        .buttons     (buttons),
        .press       (press),
        .chord       (chord)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each pin is seen through a 2-sample delay; the accepted level flips once
    // the last DEB delayed samples all show the opposite value.
    logic [N-1:0]   m_d1, m_d2, m_stable, m_code, m_buttons;
    logic           m_press, m_chord;
    logic [DEB-1:0] m_win [N];
    int             m_mode; // 0 idle, 1 held, 2 chord, 3 wait-all-released

    always @(posedge clock or negedge reset) begin : model
        logic [DEB-1:0] nw;
        logic [N-1:0]   ns;
        logic [N-1:0]   nb;
        logic           np, nc;
        int             nm;
        if (!reset) begin
            m_d1 <= '0; m_d2 <= '0; m_stable <= '0; m_code <= '0;
            m_buttons <= '0; m_press <= 1'b0; m_chord <= 1'b0; m_mode <= 0;
            for (int b = 0; b < N; b++) m_win[b] <= '0;
        end else begin
            nb = '0; np = 1'b0; nc = 1'b0; nm = m_mode;
            if (!enable) nm = 0;
            else begin
                case (m_mode)
                    0: if (m_stable != 0) begin
                        if ($countones(m_stable) == 1) begin
                            nm = 1; m_code <= m_stable; nb = m_stable; np = 1'b1;
                        end else begin
                            nm = 2; nc = 1'b1;
                        end
                    end
                    1: if ((m_stable & m_code) == 0) nm = 3; else nb = m_code;
                    default: if (m_stable == 0) nm = 0;
                endcase
            end
            ns = m_stable;
            for (int b = 0; b < N; b++) begin
                nw = {m_win[b][DEB-2:0], m_d2[b]};
                m_win[b] <= nw;
                if (nw == {DEB{~m_stable[b]}}) ns[b] = ~m_stable[b];
            end
            m_stable  <= ns;
            m_d2      <= m_d1;
            m_d1      <= raw;
            m_mode    <= nm;
            m_buttons <= nb;
            m_press   <= np;
            m_chord   <= nc;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clock) begin
        chk("buttons_vs_model", int'(buttons), int'(m_buttons));
        chk("press_vs_model", int'(press), int'(m_press));
        chk("chord_vs_model", int'(chord), int'(m_chord));
        chk("buttons_onehot0", int'($countones(buttons) <= 1), 1);
        chk("press_chord_excl", int'(press && chord), 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clock); #2; end
    endtask

    // what: 0 = press high, 1 = buttons zero. Returns cycles waited, -1 on timeout.
    task automatic wait_for(input int what, input int maxc, output int k);
        k = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(posedge clock); #1;
            if ((what == 0 && press) || (what == 1 && buttons == 0)) begin
                k = i;
                break;
            end
        end
        #1;
    endtask

    task automatic count_pulses(input int n, output int np, output int nc);
        np = 0; nc = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            if (press) np++;
            if (chord) nc++;
        end
        #1;
    endtask

    int k, np, nc;

    initial begin
        reset = 1'b0; enable = 1'b1; raw = '0;
        #1;
        chk("reset_buttons", int'(buttons), 0);
        chk("reset_press", int'(press), 0);
        chk("reset_chord", int'(chord), 0);
        tick(3);
        reset = 1'b1;
        tick(5);

        // clean press, held 50 cycles
        raw = 7'b0000100;
        wait_for(0, 40, k);
        chk("clean_press_latency", k, 23);
        chk("clean_buttons", int'(buttons), 4);
        count_pulses(27, np, nc);
        chk("clean_single_pulse", np, 0);
        raw = '0;
        wait_for(1, 40, k);
        chk("clean_release_latency", k, 23);
        tick(5);

        // bouncing press
        repeat (5) begin raw = 7'b0000001; tick(3); raw = '0; tick(3); end
        raw = 7'b0000001;
        wait_for(0, 60, k);
        chk("bounce_press_latency", k, 23);
        count_pulses(30, np, nc);
        chk("bounce_one_pulse", np, 0);
        raw = '0; tick(30);

        // short glitch
        raw = 7'b0001000; tick(10); raw = '0;
        count_pulses(40, np, nc);
        chk("glitch_no_press", np, 0);
        chk("glitch_buttons", int'(buttons), 0);

        // chord
        raw = 7'b0010001;
        count_pulses(40, np, nc);
        chk("chord_no_press", np, 0);
        chk("chord_once", nc, 1);
        raw = 7'b0010000;
        count_pulses(40, np, nc);
        chk("chord_partial_no_press", np, 0);
        raw = '0; tick(30);
        raw = 7'b0000001;
        wait_for(0, 40, k);
        chk("after_chord_press", k, 23);
        raw = '0; tick(30);

        // extra button while held
        raw = 7'b0000010;
        wait_for(0, 40, k);
        chk("hold1_press", k, 23);
        tick(40);
        raw = 7'b0100010;
        count_pulses(40, np, nc);
        chk("extra_bit_no_press", np + nc, 0);
        chk("extra_bit_buttons", int'(buttons), 2);
        raw = 7'b0100000;
        wait_for(1, 40, k);
        chk("hold1_release", k, 23);
        count_pulses(40, np, nc);
        chk("bit5_alone_no_press", np, 0);
        raw = '0; tick(30);
        raw = 7'b0100000;
        wait_for(0, 40, k);
        chk("bit5_repress", k, 23);
        chk("bit5_buttons", int'(buttons), 32);
        raw = '0; tick(30);

        // reset mid-held
        raw = 7'b0001000;
        wait_for(0, 40, k);
        tick(5);
        reset = 1'b0;
        #1;
        chk("async_reset_buttons", int'(buttons), 0);
        tick(3);
        reset = 1'b1;
        wait_for(0, 40, k);
        chk("press_after_reset", k, 23);

        // enable low mid-held
        tick(5);
        enable = 1'b0;
        tick(5);
        chk("enable_low_buttons", int'(buttons), 0);
        enable = 1'b1;
        wait_for(0, 5, k);
        chk("enable_refire", k, 1);
        raw = '0; tick(30);

        // randomized traffic
        for (int it = 0; it < 150; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                raw = '0;
                raw[$urandom_range(0, N-1)] = 1'b1;
                tick($urandom_range(1, 60));
            end else if (r < 7) begin
                raw = N'($urandom);
                tick($urandom_range(1, 45));
            end else if (r == 7) begin
                raw = '0;
                tick($urandom_range(1, 45));
            end else if (r == 8) begin
                enable = 1'b0;
                tick($urandom_range(1, 10));
                enable = 1'b1;
                tick($urandom_range(1, 10));
            end else if ($urandom_range(0, 3) == 0) begin
                reset = 1'b0;
                tick(2);
                reset = 1'b1;
            end
        end
        raw = '0;
        tick(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
